// File: rtl/accum_responder.sv
// rtl/accum_responder.sv - indexed multiply-accumulate responder producing one dot product per pass
module accum_responder #(
  parameter int N  = 16,
  parameter int DW = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reg_rst,
  input  logic                     ld,
  input  logic [15:0]              index,
  input  logic signed [DW-1:0]     x_in,
  input  logic signed [DW-1:0]     w_in,
  output logic signed [2*DW+7:0]   result,
  output logic                     result_valid,
  output logic                     busy,
  output logic                     seq_err
);

  localparam int AW = 2*DW + 8;
  localparam logic [15:0] LAST_IDX = 16'(N - 1);

  typedef enum logic [1:0] {IDLE, ARMED, ACCUM, DONE} state_t;

  state_t                  state;
  logic signed [AW-1:0]    acc;
  logic [15:0]             exp_idx;

  logic signed [2*DW-1:0]  x_ext, w_ext, prod;
  logic signed [AW-1:0]    prod_ext, acc_next;

  // Operands widened first so the product keeps all 2*DW bits.
  assign x_ext    = $signed({{DW{x_in[DW-1]}}, x_in});
  assign w_ext    = $signed({{DW{w_in[DW-1]}}, w_in});
  assign prod     = x_ext * w_ext;
  assign prod_ext = $signed({{8{prod[2*DW-1]}}, prod});
  assign acc_next = acc + prod_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      exp_idx      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      seq_err      <= 1'b0;
    end else if (reg_rst) begin
      state        <= ARMED;
      acc          <= '0;
      exp_idx      <= '0;
      seq_err      <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b1;
    end else begin
      result_valid <= 1'b0;
      case (state)
        ARMED, ACCUM: begin
          if (ld) begin
            if (index == exp_idx) begin
              acc     <= acc_next;
              exp_idx <= exp_idx + 16'd1;
              if (index == LAST_IDX) begin
                result       <= acc_next;
                state        <= DONE;
                result_valid <= 1'b1;
                busy         <= 1'b0;
              end else begin
                state <= ACCUM;
                busy  <= 1'b1;
              end
            end else begin
              seq_err <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (ld) seq_err <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (ld) seq_err <= 1'b1;
        end
      endcase
    end
  end

endmodule
